// File: rtl/tetris_pkg.sv
// Shared game definitions: game-state encodings and board geometry used by the board path.
// Also holds the frame-image rule applied when a board is captured for transmission.
package tetris_pkg;

  typedef enum logic [2:0] {
    GEN      = 3'd0,
    MOVE     = 3'd1,
    LAND     = 3'd2,
    CLEAR    = 3'd3,
    NEWBOARD = 3'd4,
    GAMEOVER = 3'd5
  } game_state_t;

  localparam int BOARD_W    = 4;
  localparam int BOARD_H    = 8;
  localparam int BOARD_BITS = BOARD_W * BOARD_H;

  // A game-over board is shown inverted so the whole display flashes to the player.
  function automatic logic [BOARD_BITS-1:0] tx_image(input logic [BOARD_BITS-1:0] board,
                                                     input logic [2:0] st);
    return (st == GAMEOVER) ? ~board : board;
  endfunction

endpackage

// File: rtl/sclk_gen.sv
// Serial clock generator: divides clka into sclk (low half first) and strobes the end of each bit.
// Held in its idle phase (div_cnt=0, sclk=0) whenever en is low.
module sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clka,
  input  logic restart,
  input  logic en,
  output logic sclk,
  output logic bit_strobe
);

  localparam int DW = $clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] HALF = DW'(CLK_DIV);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic          wrap;

  assign div_nxt    = div_cnt + DW'(1);
  assign wrap       = (div_cnt == LAST);
  assign bit_strobe = en && wrap;

  // sclk is registered from the next count so it rises exactly CLK_DIV cycles into each bit.
  always_ff @(posedge clka) begin
    if (restart || !en) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      sclk    <= (div_nxt >= HALF);
    end
  end

endmodule

// File: rtl/board_shift_tx.sv
// Board transmitter: captures a 32-bit board image on valid/ready and shifts it MSB-first
// over sdo/sclk, then pulses latch/frame_done for one cycle.
module board_shift_tx
  import tetris_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                  clka,
  input  logic                  restart,
  input  logic [BOARD_BITS-1:0] board_in,
  input  logic [2:0]            state,
  input  logic                  board_valid,
  output logic                  board_ready,
  output logic                  sdo,
  output logic                  sclk,
  output logic                  latch,
  output logic                  frame_done
);

  localparam int BC_W = $clog2(BOARD_BITS);

  // Handshake: a frame transfers on any rising edge where board_valid && board_ready;
  // board_ready is high only in IDLE, and the sender must hold board_valid until it is taken.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_LATCH = 2'd2
  } tx_fsm_t;

  tx_fsm_t               fsm;
  logic [BOARD_BITS-1:0] shadow;
  logic [BOARD_BITS-1:0] cap;
  logic [BC_W-1:0]       bit_cnt;
  logic                  shift_en;
  logic                  bit_strobe;

  assign board_ready = (fsm == TX_IDLE);
  assign shift_en    = (fsm == TX_SHIFT);
  assign cap         = tx_image(board_in, state);

  sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clka       (clka),
    .restart    (restart),
    .en         (shift_en),
    .sclk       (sclk),
    .bit_strobe (bit_strobe)
  );

  always_ff @(posedge clka) begin
    if (restart) begin
      fsm        <= TX_IDLE;
      shadow     <= '0;
      bit_cnt    <= '0;
      sdo        <= 1'b0;
      latch      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (fsm)
        TX_IDLE: begin
          latch      <= 1'b0;
          frame_done <= 1'b0;
          if (board_valid) begin
            shadow  <= cap;
            bit_cnt <= BC_W'(BOARD_BITS - 1);
            // First bit comes straight from the capture so it is on sdo in the first shift cycle.
            sdo     <= cap[BOARD_BITS-1];
            fsm     <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (bit_strobe) begin
            if (bit_cnt == '0) begin
              fsm        <= TX_LATCH;
              latch      <= 1'b1;
              frame_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt - BC_W'(1);
              sdo     <= shadow[bit_cnt - BC_W'(1)];
            end
          end
        end
        TX_LATCH: begin
          latch      <= 1'b0;
          frame_done <= 1'b0;
          fsm        <= TX_IDLE;
        end
        default: begin
          latch      <= 1'b0;
          frame_done <= 1'b0;
          fsm        <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_shift_tx.sv
// Bench for board_shift_tx: one instance at CLK_DIV=2, one at CLK_DIV=1, checked against a
// chain model that shifts sdo on every observed sclk rising edge.
module tb_board_shift_tx;

  // ---------------- clock / reset ----------------
  logic clka = 1'b0;
  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  logic        restart = 1'b1;
  logic [31:0] board_in = '0;
  logic [2:0]  state = 3'd0;
  logic [1:0]  valid = '0;
  logic [1:0]  ready, sdo, sclk, latch, done;

  board_shift_tx #(.CLK_DIV(2)) dut0 (
    .clka(clka), .restart(restart), .board_in(board_in), .state(state),
    .board_valid(valid[0]), .board_ready(ready[0]), .sdo(sdo[0]), .sclk(sclk[0]),
    .latch(latch[0]), .frame_done(done[0])
  );

  board_shift_tx #(.CLK_DIV(1)) dut1 (
    .clka(clka), .restart(restart), .board_in(board_in), .state(state),
    .board_valid(valid[1]), .board_ready(ready[1]), .sdo(sdo[1]), .sclk(sclk[1]),
    .latch(latch[1]), .frame_done(done[1])
  );

  // ---------------- chain model (LED shift register) ----------------
  logic [31:0] rx[2]     = '{32'd0, 32'd0};
  int          nbits[2]  = '{0, 0};
  int          nlatch[2] = '{0, 0};
  int          viol[2]   = '{0, 0};
  logic [1:0]  psclk = '0;
  logic [1:0]  psdo  = '0;

  always @(negedge clka) begin
    for (int g = 0; g < 2; g++) begin
      if (sclk[g] && !psclk[g]) begin
        rx[g]    <= {rx[g][30:0], sdo[g]};
        nbits[g] <= nbits[g] + 1;
      end
      if (sdo[g] != psdo[g] && sclk[g]) viol[g] <= viol[g] + 1;
      if (latch[g]) nlatch[g] <= nlatch[g] + 1;
      psclk[g] <= sclk[g];
      psdo[g]  <= sdo[g];
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int acc_cyc = 0;
  int nb_start = 0;

  task automatic tick();
    @(negedge clka);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input int g, input logic [31:0] d, input logic [2:0] st, input bit hold);
    int n;
    n = 0;
    board_in = d;
    state    = st;
    valid[g] = 1'b1;
    while (!ready[g] && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      check("ready_timeout", 32'd0, 32'd1);
    end
    acc_cyc  = cyc;
    nb_start = nbits[g];
    exp_q.push_back((st == 3'b101) ? ~d : d);
    tick();
    if (!hold) valid[g] = 1'b0;
    check("busy_after_accept", 32'(ready[g]), 32'd0);
  endtask

  task automatic wait_frame(input int g, input int cd);
    int n;
    logic [31:0] exp;
    n = 0;
    while (latch[g] !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) begin
      check("latch_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end else begin
      check("latch_latency", 32'(cyc - acc_cyc), 32'(64 * cd + 1));
      check("frame_done_with_latch", 32'(done[g]), 32'd1);
      check("sclk_low_in_latch", 32'(sclk[g]), 32'd0);
      exp = exp_q.pop_front();
      check("rx_word", rx[g], exp);
      check("bit_count", 32'(nbits[g] - nb_start), 32'd32);
      check("sdo_stable_at_sclk_high", 32'(viol[g]), 32'd0);
      tick();
      check("latch_one_cycle", 32'(latch[g]), 32'd0);
      check("frame_done_one_cycle", 32'(done[g]), 32'd0);
      check("ready_latency", 32'(ready[g]) + 32'(cyc - acc_cyc), 32'(64 * cd + 3));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] d;
    logic [2:0]  st;
    int          nl;
    int          n;

    // 1. reset
    restart = 1'b1;
    tick();
    tick();
    restart = 1'b0;
    tick();
    check("reset_ready0", 32'(ready[0]), 32'd1);
    check("reset_ready1", 32'(ready[1]), 32'd1);
    check("reset_sclk", 32'(sclk[0]), 32'd0);
    check("reset_sdo", 32'(sdo[0]), 32'd0);
    check("reset_latch", 32'(latch[0]), 32'd0);
    check("reset_frame_done", 32'(done[0]), 32'd0);

    // 2. basic frame, state=MOVE
    send(0, 32'hA5C3_0F81, 3'b001, 1'b0);
    wait_frame(0, 2);
    check("idle_sclk", 32'(sclk[0]), 32'd0);

    // 3. game-over frame is inverted
    send(0, 32'h0000_FFFF, 3'b101, 1'b0);
    wait_frame(0, 2);

    // 4. busy: valid held, data changed mid-transfer
    send(0, 32'hCAFE_F00D, 3'b010, 1'b1);
    repeat (40) tick();
    board_in = 32'h1234_5678;
    state    = 3'b001;
    wait_frame(0, 2);
    acc_cyc  = cyc;
    nb_start = nbits[0];
    exp_q.push_back(32'h1234_5678);
    tick();
    valid[0] = 1'b0;
    check("back_to_back_accept", 32'(ready[0]), 32'd0);
    wait_frame(0, 2);

    // randomized frames across all game states
    for (int i = 0; i < 5; i++) begin
      d  = $urandom;
      st = 3'($urandom_range(0, 5));
      send(0, d, st, 1'b0);
      wait_frame(0, 2);
    end

    // 5. reset mid-frame
    send(0, $urandom, 3'b011, 1'b0);
    n = 0;
    while ((nbits[0] - nb_start) < 22 && n < 2000) begin
      tick();
      n++;
    end
    nl = nlatch[0];
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("abort_sclk", 32'(sclk[0]), 32'd0);
    check("abort_latch", 32'(latch[0]), 32'd0);
    check("abort_frame_done", 32'(done[0]), 32'd0);
    check("abort_ready", 32'(ready[0]), 32'd1);
    exp_q.delete();
    repeat (200) tick();
    check("abort_no_latch", 32'(nlatch[0] - nl), 32'd0);
    send(0, 32'h0F0F_3C3C, 3'b100, 1'b0);
    wait_frame(0, 2);

    // 6. CLK_DIV=1 instance
    send(1, 32'hFFFF_FFFF, 3'b001, 1'b0);
    wait_frame(1, 1);
    d = $urandom;
    send(1, d, 3'b101, 1'b0);
    wait_frame(1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
